ext_mem_bridge: RTL and testbench

//  Parametrised successor of the single-port cache wrapper that connects a memory/cache model to a Koika external-function port.
//  - Unpacks Koika's packed arg into a put (request) channel and a get (response) channel.
//  - Packs ready/response back into out.
//  - Unlike a pure wire wrapper, it buffers both directions in FIFOs and bounds outstanding requests.
//  - Latches the model's finish and flags Koika-side protocol errors.
//  - Sits between the Koika top and any valid/ready memory model (cache, DRAM stub).

---
 rtl/ext_mem_bridge.sv | 182 ++++++++++++++++++
 tb/tb_ext_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: connects a Koika external-function port to a valid/ready
// memory model. Requests and responses are buffered in small circular FIFOs,
// the number of requests the Koika side has issued but not yet collected is
// bounded, the model's finish indication is latched, and Koika-side protocol
// violations raise a sticky error flag.

// Circular FIFO with show-ahead head. Pointers carry one extra wrap bit so
// full and empty fall out of a straight pointer compare.
module ext_mem_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO refuses a push even if it pops in the same cycle, and a pop
  // on an empty FIFO is ignored, so push+pop on empty only pushes.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head reads as zero while empty so stale storage never leaks out,
  // including entries left behind by a reset.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write at the tail.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// Top-level bridge.
module ext_mem_bridge #(
  parameter int REQ_W     = 70,
  parameter int RESP_W    = 52,
  parameter int DEPTH     = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REQ_W+1:0]  arg,
  output logic [RESP_W+1:0] out,
  output logic              finish,
  output logic              err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [REQ_W-1:0]  mem_req_data,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [RESP_W-1:0] mem_resp_data,
  input  logic              mem_finish
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_LIMIT = OW'(MAX_OUTST);

  logic              get_valid;
  logic              put_valid;
  logic [REQ_W-1:0]  put_request;
  logic              get_ready;
  logic              put_ready;
  logic [RESP_W-1:0] get_response;

  logic              req_full;
  logic              req_empty;
  logic              resp_full;
  logic              resp_empty;

  logic              put_acc;
  logic              get_acc;
  logic              err_set;
  logic [OW-1:0]     outst;
  logic [OW-1:0]     outst_next;

  // Koika packs {get_valid, put_valid, put_request}.
  assign get_valid   = arg[REQ_W+1];
  assign put_valid   = arg[REQ_W];
  assign put_request = arg[REQ_W-1:0];

  // All ready terms come from registered state only.
  assign put_ready      = !req_full && (outst < OUTST_LIMIT);
  assign get_ready      = !resp_empty;
  assign mem_req_valid  = !req_empty;
  assign mem_resp_ready = !resp_full;

  assign put_acc = put_valid && put_ready;
  assign get_acc = get_valid && get_ready;

  assign out = {get_ready, put_ready, get_response};

  ext_mem_bridge_fifo #(
    .W     (REQ_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (put_acc),
    .push_data (put_request),
    .pop       (mem_req_ready),
    .full      (req_full),
    .empty     (req_empty),
    .head      (mem_req_data)
  );

  ext_mem_bridge_fifo #(
    .W     (RESP_W),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (mem_resp_valid),
    .push_data (mem_resp_data),
    .pop       (get_valid),
    .full      (resp_full),
    .empty     (resp_empty),
    .head      (get_response)
  );

  // Outstanding count and error detection. put_ready already caps the count
  // at MAX_OUTST, and a get with nothing outstanding (unsolicited response)
  // is flagged rather than allowed to underflow.
  always_comb begin
    outst_next = outst;
    if (put_acc && !get_acc) begin
      outst_next = outst + OW'(1);
    end else if (!put_acc && get_acc && (outst != '0)) begin
      outst_next = outst - OW'(1);
    end
    err_set = (get_valid && !get_ready) ||
              (put_valid && !put_ready) ||
              (get_acc && (outst == '0));
  end

  // Outstanding counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) outst <= '0;
    else     outst <= outst_next;
  end

  // Sticky error and finish flags; only reset clears them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err    <= 1'b0;
      finish <= 1'b0;
    end else begin
      if (err_set)    err    <= 1'b1;
      if (mem_finish) finish <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Scoreboard bench for ext_mem_bridge: the stimulus pushes expected request
// and response payloads into queues, a monitor pops and compares them at
// every handshake; flag and ready values are checked inline by the stimulus.
module tb_ext_mem_bridge;

  localparam int REQ_W  = 70;
  localparam int RESP_W = 52;

  logic              CLK;
  logic              RST;
  logic              get_valid;
  logic              put_valid;
  logic [REQ_W-1:0]  put_request;
  logic [REQ_W+1:0]  arg;
  logic [RESP_W+1:0] out;
  logic              finish;
  logic              err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [REQ_W-1:0]  mem_req_data;
  logic              mem_resp_valid;
  logic              mem_resp_ready;
  logic [RESP_W-1:0] mem_resp_data;
  logic              mem_finish;

  logic              get_ready;
  logic              put_ready;
  logic [RESP_W-1:0] get_response;

  int checks   = 0;
  int failures = 0;

  logic [REQ_W-1:0]  req_q [$];
  logic [RESP_W-1:0] get_q [$];

  assign arg          = {get_valid, put_valid, put_request};
  assign get_ready    = out[RESP_W+1];
  assign put_ready    = out[RESP_W];
  assign get_response = out[RESP_W-1:0];

  ext_mem_bridge #(
    .REQ_W     (REQ_W),
    .RESP_W    (RESP_W),
    .DEPTH     (2),
    .MAX_OUTST (2)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .arg            (arg),
    .out            (out),
    .finish         (finish),
    .err            (err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_data  (mem_resp_data),
    .mem_finish     (mem_finish)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    logic [REQ_W-1:0]  er;
    logic [RESP_W-1:0] eg;
    forever begin
      @(negedge CLK);
      #4;
      if (!RST) begin
        if (mem_req_valid && mem_req_ready) begin
          if (req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_unexpected actual=%0h required=none", mem_req_data);
          end else begin
            er = req_q.pop_front();
            chk("req_data", 128'(mem_req_data), 128'(er));
          end
        end
        if (get_valid && get_ready) begin
          if (get_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL get_unexpected actual=%0h required=none", get_response);
          end else begin
            eg = get_q.pop_front();
            chk("get_response", 128'(get_response), 128'(eg));
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REQ_W-1:0]  rq;
    logic [RESP_W-1:0] rs;
    RST = 1'b1;
    get_valid = 0; put_valid = 0; put_request = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0; mem_finish = 0;

    // 1: reset
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("reset_out", 128'(out), 128'({1'b0, 1'b1, 52'h0}));
    chk("reset_finish", 128'(finish), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    chk("reset_req_valid", 128'(mem_req_valid), 128'(0));
    chk("reset_req_data", 128'(mem_req_data), 128'(0));
    chk("reset_resp_ready", 128'(mem_resp_ready), 128'(1));

    // 2: single round trip
    @(negedge CLK);
    chk("rt_put_ready", 128'(put_ready), 128'(1));
    put_request = 70'h155; put_valid = 1; req_q.push_back(70'h155);
    @(negedge CLK);
    put_valid = 0;
    chk("rt_req_valid", 128'(mem_req_valid), 128'(1));
    chk("rt_req_data", 128'(mem_req_data), 128'(70'h155));
    mem_req_ready = 1;
    @(negedge CLK);
    mem_req_ready = 0;
    chk("rt_req_drained", 128'(mem_req_valid), 128'(0));
    @(negedge CLK);
    chk("rt_resp_ready", 128'(mem_resp_ready), 128'(1));
    mem_resp_valid = 1; mem_resp_data = 52'hABC; get_q.push_back(52'hABC);
    @(negedge CLK);
    mem_resp_valid = 0;
    chk("rt_get_ready", 128'(get_ready), 128'(1));
    chk("rt_get_resp", 128'(get_response), 128'(52'hABC));
    get_valid = 1;
    @(negedge CLK);
    get_valid = 0;
    chk("rt_get_ready_after", 128'(get_ready), 128'(0));
    chk("rt_err", 128'(err), 128'(0));

    // 4: six round trips, put k+1 in the same cycle as get k
    mem_req_ready = 1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge CLK);
      put_valid = 0; mem_resp_valid = 0; get_valid = 0;
      if ((c % 2 == 0) && (c / 2 < 6)) begin
        rq = {6'h2A, 64'(c / 2 * 17 + 3)};
        chk("wrap_put_ready", 128'(put_ready), 128'(1));
        put_request = rq; put_valid = 1; req_q.push_back(rq);
      end
      if ((c % 2 == 1) && ((c - 1) / 2 < 6)) begin
        rs = 52'hF0000_0000_0000 + 52'((c - 1) / 2 * 257 + 9);
        mem_resp_valid = 1; mem_resp_data = rs; get_q.push_back(rs);
      end
      if ((c % 2 == 0) && (c >= 2)) begin
        chk("wrap_get_ready", 128'(get_ready), 128'(1));
        get_valid = 1;
      end
    end
    @(negedge CLK);
    put_valid = 0; mem_resp_valid = 0; get_valid = 0; mem_req_ready = 0;
    chk("wrap_err", 128'(err), 128'(0));
    chk("wrap_get_idle", 128'(get_ready), 128'(0));
    chk("wrap_req_idle", 128'(mem_req_valid), 128'(0));

    // 3: outstanding limit with the model stalled
    @(negedge CLK);
    chk("lim_put1_ready", 128'(put_ready), 128'(1));
    put_request = 70'h1; put_valid = 1; req_q.push_back(70'h1);
    @(negedge CLK);
    chk("lim_put2_ready", 128'(put_ready), 128'(1));
    put_request = 70'h2; req_q.push_back(70'h2);
    @(negedge CLK);
    chk("lim_put3_ready", 128'(put_ready), 128'(0));
    put_request = 70'h3;
    @(negedge CLK);
    put_valid = 0;
    chk("lim_err", 128'(err), 128'(1));
    chk("lim_head", 128'(mem_req_data), 128'(70'h1));
    mem_req_ready = 1;
    @(negedge CLK);
    @(negedge CLK);
    mem_req_ready = 0;
    chk("lim_req_empty", 128'(mem_req_valid), 128'(0));
    chk("lim_still_blocked", 128'(put_ready), 128'(0));
    mem_resp_valid = 1; mem_resp_data = 52'h1111; get_q.push_back(52'h1111);
    @(negedge CLK);
    mem_resp_data = 52'h2222; get_q.push_back(52'h2222);
    @(negedge CLK);
    mem_resp_valid = 0;
    chk("lim_resp_full", 128'(mem_resp_ready), 128'(0));
    chk("lim_get1_ready", 128'(get_ready), 128'(1));
    get_valid = 1;
    @(negedge CLK);
    chk("lim_get2_ready", 128'(get_ready), 128'(1));
    @(negedge CLK);
    get_valid = 0;
    chk("lim_get_done", 128'(get_ready), 128'(0));
    chk("lim_put_free", 128'(put_ready), 128'(1));

    // Reset mid-transfer discards the buffered request
    put_request = 70'hDEAD; put_valid = 1;
    @(negedge CLK);
    put_valid = 0;
    chk("mid_req_valid", 128'(mem_req_valid), 128'(1));
    RST = 1;
    #1;
    chk("async_reset_req_valid", 128'(mem_req_valid), 128'(0));
    chk("async_reset_err", 128'(err), 128'(0));
    @(negedge CLK);
    RST = 0;
    chk("mid_req_data", 128'(mem_req_data), 128'(0));
    chk("mid_out", 128'(out), 128'({1'b0, 1'b1, 52'h0}));

    // 5: underflow and finish
    @(negedge CLK);
    chk("uf_get_ready", 128'(get_ready), 128'(0));
    get_valid = 1;
    @(negedge CLK);
    get_valid = 0;
    chk("uf_err", 128'(err), 128'(1));
    chk("uf_out", 128'(out), 128'({1'b0, 1'b1, 52'h0}));
    chk("uf_resp_ready", 128'(mem_resp_ready), 128'(1));
    @(negedge CLK);
    chk("fin_before", 128'(finish), 128'(0));
    mem_finish = 1;
    @(negedge CLK);
    mem_finish = 0;
    chk("fin_set", 128'(finish), 128'(1));
    @(negedge CLK);
    chk("fin_held", 128'(finish), 128'(1));
    RST = 1;
    @(negedge CLK);
    RST = 0;
    chk("fin_reset", 128'(finish), 128'(0));
    chk("err_reset", 128'(err), 128'(0));

    // Unsolicited response: data still delivered, err raised
    @(negedge CLK);
    mem_resp_valid = 1; mem_resp_data = 52'h5A5A5; get_q.push_back(52'h5A5A5);
    @(negedge CLK);
    mem_resp_valid = 0;
    get_valid = 1;
    @(negedge CLK);
    get_valid = 0;
    chk("unsol_err", 128'(err), 128'(1));
    chk("unsol_get_ready", 128'(get_ready), 128'(0));

    @(negedge CLK);
    chk("req_q_drained", 128'(req_q.size()), 128'(0));
    chk("get_q_drained", 128'(get_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
